hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
// - Drives the control side of the ID/EX boundary: detects load-use hazards between ID/EX and IF/ID and stalls them.
// - Inserts bubbles into ID/EX and flushes IF/ID, ID/EX and EX/MEM on a taken branch resolved in MEM.
// - Outputs feed the PC write enable, the IF/ID write enable, the ID/EX control-zero mux and the per-stage flush inputs.
// PARAMETERS
// - STALL_CYC  default 1   bubbles inserted per load-use hazard (1 = MEM->EX forwarding present, 2 = none); legal 1..3
// - CNT_W      default 16  width of performance counters (HAZARD_PERF_EN only)
// PORTS
// - clk          in   1      rising-edge clock
// - rst_n        in   1      synchronous reset, active low
// - IDEX_MemRead in   1      MemRead at the ID/EX register output
// - IDEX_rt      in   5      rt at the ID/EX register output (load destination)
// - IFID_rs      in   5      rs field of the instruction in ID
// - IFID_rt      in   5      rt field of the instruction in ID
// - IFID_UsesRt  in   1      ID instruction reads rt as a source (R-type, beq, sw)
// - BranchTaken  in   1      branch taken, resolved in MEM from EX/MEM Branch & Zero
// - PCWrite      out  1      PC load enable
// - IFIDWrite    out  1      IF/ID load enable
// - CtrlBubble   out  1      force all ID/EX control inputs to 0
// - IFIDFlush    out  1      clear IF/ID at next edge
// - IDEXFlush    out  1      clear ID/EX control at next edge
// - EXMEMFlush   out  1      clear EX/MEM control at next edge
// - StallCnt     out  CNT_W  load-use bubble count (HAZARD_PERF_EN only)
// - FlushCnt     out  CNT_W  taken-branch flush count (HAZARD_PERF_EN only)
// BEHAVIOUR
// - Only sequential state is the FSM {RUN, STALL} plus a 2-bit remaining-bubble counter rem; outputs are combinational from state and inputs (zero latency).
// - Reset (rst_n=0 at an edge): state=RUN, rem=0.
// - While rst_n=0: PCWrite=0, IFIDWrite=0, CtrlBubble=1, all flushes=1, so the pipeline fills with bubbles.
// - Hazard: hz = IDEX_MemRead & (IDEX_rt!=0) & ((IDEX_rt==IFID_rs) | (IFID_UsesRt & (IDEX_rt==IFID_rt))).
//   - Register $0 never causes a hazard.
// - RUN, BranchTaken=1:
//   - PCWrite=1, IFIDWrite=1, IFIDFlush=IDEXFlush=EXMEMFlush=1, CtrlBubble=0.
//   - Stay RUN; hz is ignored.
// - RUN, hz=1, no branch:
//   - PCWrite=0, IFIDWrite=0, CtrlBubble=1, no flushes.
//   - If STALL_CYC>1: next STALL, rem=STALL_CYC-1. Otherwise stay RUN.
// - RUN, neither: PCWrite=1, IFIDWrite=1, all other outputs 0.
// - STALL, no branch:
//   - Same outputs as a hazard cycle; rem decrements each cycle.
//   - When rem==1, next state is RUN.
//   - hz is not re-evaluated here, because ID/EX already holds a bubble.
// - STALL, BranchTaken=1: branch outputs as in RUN; next RUN, rem=0 (the stalled instruction is squashed anyway).
// - Priority: reset > BranchTaken > STALL hold > hz > normal.
// - Back-to-back loads: a new hz on the first RUN cycle after STALL starts a fresh stall.
// - Reset mid-stall aborts to RUN on the next edge; no pending bubbles survive.
// CONFIGURATION
// - HAZARD_PERF_EN defined:
//   - StallCnt increments once per cycle with CtrlBubble=1 and no branch.
//   - FlushCnt increments once per cycle with BranchTaken=1.
//   - Both counters saturate at all-ones and reset to 0.
// - HAZARD_PERF_EN undefined: counters absent; StallCnt and FlushCnt are tied to 0.
// STRUCTURE
// - hazard_pkg: state encoding (RUN=1'b0, STALL=1'b1), REG_ZERO=5'd0, and a STALL_CYC legality check.
// - Sub-module hazard_perf_cnt (one saturating CNT_W counter with inc and rst_n), instantiated twice under HAZARD_PERF_EN.
// - FSM, rem counter and output decode stay in hazard_ctrl.
// TESTING
// - Load then use: IDEX_MemRead=1, IDEX_rt=8, IFID_rs=8, STALL_CYC=1 -> one cycle of PCWrite=0, IFIDWrite=0, CtrlBubble=1, then normal.
// - $0 and rt gating:
//   - IDEX_rt=0, IFID_rs=0 -> no stall.
//   - IFID_rt=9, IDEX_rt=9, IFID_UsesRt=0 -> no stall; with IFID_UsesRt=1 -> stall.
// - STALL_CYC=2: hazard on rt=5 -> exactly 2 consecutive bubble cycles.
//   - IDEX_MemRead drops in the 2nd cycle; stall still held.
// - BranchTaken=1 together with hz=1 -> all three flushes=1, PCWrite=1, CtrlBubble=0.
//   - With STALL_CYC=2 and a branch in the STALL cycle -> RUN next cycle, no further bubble.
// - Reset: rst_n=0 for 2 cycles during STALL -> outputs at reset values.
//   - After release with no hazard -> PCWrite=1 on the first cycle.
// - HAZARD_PERF_EN, CNT_W=2: 5 bubbles -> StallCnt=3 (saturated); 2 branches -> FlushCnt=2.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the load-use / branch hazard controller.
package hazard_pkg;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic stall_cyc_ok(input int n);
    return (n >= 1) && (n <= 3);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl: hazard sources in, stall/flush controls out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             IDEX_MemRead;
  logic [4:0]       IDEX_rt;
  logic [4:0]       IFID_rs;
  logic [4:0]       IFID_rt;
  logic             IFID_UsesRt;
  logic             BranchTaken;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             CtrlBubble;
  logic             IFIDFlush;
  logic             IDEXFlush;
  logic             EXMEMFlush;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output IDEX_MemRead, IDEX_rt, IFID_rs, IFID_rt, IFID_UsesRt, BranchTaken,
    input  PCWrite, IFIDWrite, CtrlBubble, IFIDFlush, IDEXFlush, EXMEMFlush,
    input  StallCnt, FlushCnt
  );

  modport slave (
    input  IDEX_MemRead, IDEX_rt, IFID_rs, IFID_rt, IFID_UsesRt, BranchTaken,
    output PCWrite, IFIDWrite, CtrlBubble, IFIDFlush, IDEXFlush, EXMEMFlush,
    output StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with synchronous active-low clear.
module hazard_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// ID/EX hazard controller: load-use stall and MEM-resolved branch flush.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
//
// state | meaning
// RUN   | normal issue; load-use hazards checked each cycle
// STALL | extra bubble cycles after a hazard when STALL_CYC > 1; rem counts down
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int STALL_CYC = 1,
  parameter int CNT_W     = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave hif
);

  generate
    if (!stall_cyc_ok(STALL_CYC)) begin : g_bad_stall_cyc
      $error("hazard_ctrl: STALL_CYC must be 1..3");
    end
  endgenerate

  logic [0:0] state_q, state_d;
  logic [1:0] rem_q, rem_d;
  logic       hz;

  assign hz = hif.IDEX_MemRead && (hif.IDEX_rt != REG_ZERO) &&
              ((hif.IDEX_rt == hif.IFID_rs) ||
               (hif.IFID_UsesRt && (hif.IDEX_rt == hif.IFID_rt)));

  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    hif.PCWrite    = 1'b1;
    hif.IFIDWrite  = 1'b1;
    hif.CtrlBubble = 1'b0;
    hif.IFIDFlush  = 1'b0;
    hif.IDEXFlush  = 1'b0;
    hif.EXMEMFlush = 1'b0;
    if (!rst_n) begin
      hif.PCWrite    = 1'b0;
      hif.IFIDWrite  = 1'b0;
      hif.CtrlBubble = 1'b1;
      hif.IFIDFlush  = 1'b1;
      hif.IDEXFlush  = 1'b1;
      hif.EXMEMFlush = 1'b1;
      state_d        = ST_RUN;
      rem_d          = 2'd0;
    end else if (hif.BranchTaken) begin
      // the stalled instruction is squashed by the flush, so pending bubbles are dropped
      hif.IFIDFlush  = 1'b1;
      hif.IDEXFlush  = 1'b1;
      hif.EXMEMFlush = 1'b1;
      state_d        = ST_RUN;
      rem_d          = 2'd0;
    end else if (state_q == ST_STALL) begin
      hif.PCWrite    = 1'b0;
      hif.IFIDWrite  = 1'b0;
      hif.CtrlBubble = 1'b1;
      rem_d          = rem_q - 2'd1;
      if (rem_q == 2'd1) state_d = ST_RUN;
    end else if (hz) begin
      hif.PCWrite    = 1'b0;
      hif.IFIDWrite  = 1'b0;
      hif.CtrlBubble = 1'b1;
      if (STALL_CYC > 1) begin
        state_d = ST_STALL;
        rem_d   = 2'(STALL_CYC - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic stall_inc, flush_inc;

  assign stall_inc = rst_n && hif.CtrlBubble && !hif.BranchTaken;
  assign flush_inc = rst_n && hif.BranchTaken;

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (stall_inc),
    .cnt_o (hif.StallCnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (flush_inc),
    .cnt_o (hif.FlushCnt)
  );
`else
  assign hif.StallCnt = '0;
  assign hif.FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (STALL_CYC=1 and 2) share stimulus.
module tb_hazard_ctrl;

  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hif1 ();
  hazard_ctrl_if #(.CNT_W(CW)) hif2 ();

  hazard_ctrl #(.STALL_CYC(1), .CNT_W(CW)) dut1 (.clk(clk), .rst_n(rst_n), .hif(hif1));
  hazard_ctrl #(.STALL_CYC(2), .CNT_W(CW)) dut2 (.clk(clk), .rst_n(rst_n), .hif(hif2));

  typedef struct {
    logic [5:0] o1;
    logic [5:0] o2;
    int         sc1, fc1, sc2, fc2;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   stim_done = 1'b0;

  // reference model state: bubbles still owed and counter values
  int pend1 = 0, pend2 = 0;
  int sc1 = 0, fc1 = 0, sc2 = 0, fc2 = 0;

  logic       s_rst, s_mr, s_uses, s_br;
  logic [4:0] s_idrt, s_rs, s_rt;

  // outputs as {PCWrite, IFIDWrite, CtrlBubble, IFIDFlush, IDEXFlush, EXMEMFlush}
  task automatic model_step(input int stall_cyc, inout int pend, inout int sc, inout int fc,
                            output logic [5:0] o);
    bit hz;
    bit bubble;
    hz = s_mr && (s_idrt != 0) && ((s_idrt == s_rs) || (s_uses && (s_idrt == s_rt)));
    bubble = 1'b0;
    if (!s_rst) begin
      o = 6'b001111;
      pend = 0;
    end else if (s_br) begin
      o = 6'b110111;
      pend = 0;
    end else if (pend > 0) begin
      o = 6'b001000;
      bubble = 1'b1;
      pend--;
    end else if (hz) begin
      o = 6'b001000;
      bubble = 1'b1;
      pend = stall_cyc - 1;
    end else begin
      o = 6'b110000;
    end
`ifdef HAZARD_PERF_EN
    if (!s_rst) begin
      sc = 0;
      fc = 0;
    end else begin
      if (bubble && sc < (1 << CW) - 1) sc++;
      if (s_br && fc < (1 << CW) - 1) fc++;
    end
`endif
  endtask

  task automatic apply(input logic rst, input logic mr, input logic [4:0] idrt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic br, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst;
    hif1.IDEX_MemRead = mr;  hif2.IDEX_MemRead = mr;
    hif1.IDEX_rt      = idrt; hif2.IDEX_rt     = idrt;
    hif1.IFID_rs      = rs;  hif2.IFID_rs      = rs;
    hif1.IFID_rt      = rt;  hif2.IFID_rt      = rt;
    hif1.IFID_UsesRt  = uses; hif2.IFID_UsesRt = uses;
    hif1.BranchTaken  = br;  hif2.BranchTaken  = br;
    {s_rst, s_mr, s_idrt, s_rs, s_rt, s_uses, s_br} = {rst, mr, idrt, rs, rt, uses, br};
    e.sc1 = sc1; e.fc1 = fc1; e.sc2 = sc2; e.fc2 = fc2;
    model_step(1, pend1, sc1, fc1, e.o1);
    model_step(2, pend2, sc2, fc2, e.o2);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string tag);
    apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    hif1.IDEX_MemRead = 1'b0; hif2.IDEX_MemRead = 1'b0;
    hif1.IDEX_rt = '0; hif2.IDEX_rt = '0;
    hif1.IFID_rs = '0; hif2.IFID_rs = '0;
    hif1.IFID_rt = '0; hif2.IFID_rt = '0;
    hif1.IFID_UsesRt = 1'b0; hif2.IFID_UsesRt = 1'b0;
    hif1.BranchTaken = 1'b0; hif2.BranchTaken = 1'b0;
    repeat (2) @(posedge clk);
    apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, "reset");
    idle("post_reset");
    apply(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, "load_use");
    apply(1'b1, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, "load_use_drop");
    idle("after_load_use");
    apply(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, "reg_zero");
    apply(1'b1, 1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0, "rt_unused");
    apply(1'b1, 1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b0, "rt_used");
    apply(1'b1, 1'b0, 5'd0, 5'd1, 5'd9, 1'b1, 1'b0, "rt_used_hold");
    apply(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, "sc2_hz");
    apply(1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, "sc2_hold");
    apply(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, "back_to_back");
    apply(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, "branch_in_stall");
    idle("after_branch_stall");
    apply(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, "branch_with_hz");
    apply(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, "branch_twice");
    apply(1'b1, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, "hz_before_rst");
    apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, "rst_in_stall_a");
    apply(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, "rst_in_stall_b");
    idle("rst_release");
    for (int i = 0; i < 5; i++) apply(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, "sat_bubbles");
    apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, "sat_br_a");
    apply(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, "sat_br_b");
    idle("sat_check");
    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 40) != 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), "random");
    end
    stim_done = 1'b1;
  end

  initial begin
    exp_t e;
    int   cyc;
    cyc = 0;
    while (!(stim_done && exp_q.size() == 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() != 0) begin
        logic [5:0] a1, a2;
        e = exp_q.pop_front();
        a1 = {hif1.PCWrite, hif1.IFIDWrite, hif1.CtrlBubble, hif1.IFIDFlush, hif1.IDEXFlush, hif1.EXMEMFlush};
        a2 = {hif2.PCWrite, hif2.IFIDWrite, hif2.CtrlBubble, hif2.IFIDFlush, hif2.IDEXFlush, hif2.EXMEMFlush};
        n_vec++;
        if (a1 !== e.o1) begin
          n_bad++;
          $display("FAIL %s sc1 outputs: got %b expected %b", e.tag, a1, e.o1);
        end
        n_vec++;
        if (a2 !== e.o2) begin
          n_bad++;
          $display("FAIL %s sc2 outputs: got %b expected %b", e.tag, a2, e.o2);
        end
        n_vec++;
        if (hif1.StallCnt !== CW'(e.sc1) || hif1.FlushCnt !== CW'(e.fc1)) begin
          n_bad++;
          $display("FAIL %s sc1 counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   e.tag, hif1.StallCnt, hif1.FlushCnt, e.sc1, e.fc1);
        end
        n_vec++;
        if (hif2.StallCnt !== CW'(e.sc2) || hif2.FlushCnt !== CW'(e.fc2)) begin
          n_bad++;
          $display("FAIL %s sc2 counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   e.tag, hif2.StallCnt, hif2.FlushCnt, e.sc2, e.fc2);
        end
      end
    end
    if (!(stim_done && exp_q.size() == 0)) begin
      n_bad++;
      $display("FAIL timeout: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
